// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: QR_LANES quarter-rounds per clock, one 512-bit block per request.
// Define CHACHA_XOR_EN to add a data_in port and XOR it into the output block.
module chacha_block_core #(
    parameter int ROUNDS   = 20,
    parameter int QR_LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Once raised, out_valid stays high with keystream frozen until out_ready.
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  counter,
`ifdef CHACHA_XOR_EN
    input  logic [511:0] data_in,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream,
    output logic         busy
);

    if (!(ROUNDS == 8 || ROUNDS == 12 || ROUNDS == 20)) begin : g_bad_rounds
        $error("chacha_block_core: ROUNDS must be 8, 12 or 20");
    end
    if (!(QR_LANES == 1 || QR_LANES == 2 || QR_LANES == 4)) begin : g_bad_lanes
        $error("chacha_block_core: QR_LANES must be 1, 2 or 4");
    end

    localparam int             STEPS     = ROUNDS * 4 / QR_LANES;
    localparam int             SPD       = 8 / QR_LANES;
    localparam logic [6:0]     LAST_STEP = 7'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

    state_t        state_q;
    logic [31:0]   work_q [16];
    logic [31:0]   init_q [16];
    logic [31:0]   work_d [16];
    logic [31:0]   init_word [16];
    logic [6:0]    step_q;
    logic [511:0]  ks_q;
    logic [511:0]  final_ks;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [2:0]    sub_step;
    logic [2:0]    qr_sel;
    logic [15:0]   qr_pos;
    logic [127:0]  qr_res;
`ifdef CHACHA_XOR_EN
    logic [511:0]  data_q;
`endif

    function automatic logic [127:0] quarter_round(input logic [31:0] a_in, input logic [31:0] b_in,
                                                   input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Word indices {a,b,c,d} of quarter-round q: 0-3 are columns, 4-7 diagonals.
    function automatic logic [15:0] qr_index(input logic [2:0] q);
        logic [1:0] col;
        col = q[1:0];
        if (!q[2]) begin
            return {2'b00, col, 2'b01, col, 2'b10, col, 2'b11, col};
        end
        return {2'b00, col, 2'b01, 2'(col + 2'd1), 2'b10, 2'(col + 2'd2), 2'b11, 2'(col + 2'd3)};
    endfunction

    always_comb begin
        init_word[0] = 32'h61707865;
        init_word[1] = 32'h3320646e;
        init_word[2] = 32'h79622d32;
        init_word[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) begin
            init_word[4 + i] = key[32*i +: 32];
        end
        init_word[12] = counter;
        for (int j = 0; j < 3; j++) begin
            init_word[13 + j] = nonce[32*j +: 32];
        end
    end

    // Lanes issued together are always all-column or all-diagonal, so they touch disjoint words.
    always_comb begin
        work_d   = work_q;
        qr_sel   = '0;
        qr_pos   = '0;
        qr_res   = '0;
        sub_step = step_q[2:0] & 3'(SPD - 1);
        for (int k = 0; k < QR_LANES; k++) begin
            qr_sel = 3'(int'(sub_step) * QR_LANES + k);
            qr_pos = qr_index(qr_sel);
            qr_res = quarter_round(work_q[qr_pos[15:12]], work_q[qr_pos[11:8]],
                                   work_q[qr_pos[7:4]], work_q[qr_pos[3:0]]);
            work_d[qr_pos[15:12]] = qr_res[127:96];
            work_d[qr_pos[11:8]]  = qr_res[95:64];
            work_d[qr_pos[7:4]]   = qr_res[63:32];
            work_d[qr_pos[3:0]]   = qr_res[31:0];
        end
    end

    always_comb begin
        final_ks = '0;
        for (int i = 0; i < 16; i++) begin
            final_ks[32*i +: 32] = work_q[i] + init_q[i];
        end
`ifdef CHACHA_XOR_EN
        final_ks = final_ks ^ data_q;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            ks_q        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= '0;
                init_q[i] <= '0;
            end
`ifdef CHACHA_XOR_EN
            data_q      <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        work_q     <= init_word;
                        init_q     <= init_word;
                        step_q     <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ROUND;
`ifdef CHACHA_XOR_EN
                        data_q     <= data_in;
`endif
                    end
                end
                ROUND: begin
                    work_q <= work_d;
                    step_q <= step_q + 7'd1;
                    if (step_q == LAST_STEP) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    ks_q        <= final_ks;
                    out_valid_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign keystream = ks_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Bench for chacha_block_core: four instances (20/4, 20/2, 20/1, 8/4) share one request stream
// and are compared against an RFC-style reference block function.
module tb_chacha_block_core;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic [511:0] din;
  logic [3:0]   ov;
  logic [3:0]   ir;
  logic [3:0]   bz;
  logic [511:0] ks [4];

  logic [511:0] exp_ks [4];
  int           inst_lat [4] = '{21, 41, 81, 9};
  int           inst_rounds [4] = '{20, 20, 20, 8};
  int           n_assert = 0;
  int           n_fail = 0;

  logic [255:0] rfc_k;
  logic [95:0]  rfc_n;
  logic [255:0] rk;
  logic [95:0]  rn;
  logic [511:0] rd;

  chacha_block_core #(.ROUNDS(20), .QR_LANES(4)) u_r20l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .key(key), .nonce(nonce),
    .counter(counter),
`ifdef CHACHA_XOR_EN
    .data_in(din),
`endif
    .out_valid(ov[0]), .out_ready(out_ready), .keystream(ks[0]), .busy(bz[0]));

  chacha_block_core #(.ROUNDS(20), .QR_LANES(2)) u_r20l2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .key(key), .nonce(nonce),
    .counter(counter),
`ifdef CHACHA_XOR_EN
    .data_in(din),
`endif
    .out_valid(ov[1]), .out_ready(out_ready), .keystream(ks[1]), .busy(bz[1]));

  chacha_block_core #(.ROUNDS(20), .QR_LANES(1)) u_r20l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .key(key), .nonce(nonce),
    .counter(counter),
`ifdef CHACHA_XOR_EN
    .data_in(din),
`endif
    .out_valid(ov[2]), .out_ready(out_ready), .keystream(ks[2]), .busy(bz[2]));

  chacha_block_core #(.ROUNDS(8), .QR_LANES(4)) u_r8l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[3]), .key(key), .nonce(nonce),
    .counter(counter),
`ifdef CHACHA_XOR_EN
    .data_in(din),
`endif
    .out_valid(ov[3]), .out_ready(out_ready), .keystream(ks[3]), .busy(bz[3]));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [95:0] n,
                                              input logic [31:0] c, input int rounds);
    logic [31:0] s [16];
    logic [31:0] x [16];
    logic [31:0] a, b, cc, d;
    logic [511:0] o;
    int qa [8];
    int qb [8];
    int qc [8];
    int qd [8];
    qa = '{0, 1, 2, 3, 0, 1, 2, 3};
    qb = '{4, 5, 6, 7, 5, 6, 7, 4};
    qc = '{8, 9, 10, 11, 10, 11, 8, 9};
    qd = '{12, 13, 14, 15, 15, 12, 13, 14};
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4 + i] = k[32*i +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13 + j] = n[32*j +: 32];
    x = s;
    for (int r = 0; r < rounds; r += 2) begin
      for (int q = 0; q < 8; q++) begin
        a = x[qa[q]]; b = x[qb[q]]; cc = x[qc[q]]; d = x[qd[q]];
        a = a + b;  d = rotl(d ^ a, 16);
        cc = cc + d; b = rotl(b ^ cc, 12);
        a = a + b;  d = rotl(d ^ a, 8);
        cc = cc + d; b = rotl(b ^ cc, 7);
        x[qa[q]] = a; x[qb[q]] = b; x[qc[q]] = cc; x[qd[q]] = d;
      end
    end
    for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + s[i];
    return o;
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
    return v;
  endfunction

  // scoreboard checks
  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [255:0] k, input logic [95:0] n, input logic [31:0] c,
                         input logic [511:0] d);
    key = k;
    nonce = n;
    counter = c;
`ifdef CHACHA_XOR_EN
    din = d;
`else
    din = '0;
    if (d != d) din = d;
`endif
    for (int r = 0; r < 4; r++) exp_ks[r] = chacha_ref(k, n, c, inst_rounds[r]) ^ din;
  endtask

  // Raise in_valid for one edge, then scramble the fields to show only the accepting edge matters.
  task automatic accept();
    logic [511:0] junk;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    junk = rnd512();
    key = junk[255:0];
    nonce = junk[351:256];
    counter = junk[383:352];
`ifdef CHACHA_XOR_EN
    din = rnd512();
`endif
    for (int r = 0; r < 4; r++) begin
      chk1($sformatf("accept_in_ready[%0d]", r), ir[r], 1'b0);
      chk1($sformatf("accept_busy[%0d]", r), bz[r], 1'b1);
    end
  endtask

  task automatic wait_out();
    int lat [4];
    logic [3:0] seen;
    int cyc;
    seen = '0;
    cyc = 0;
    for (int r = 0; r < 4; r++) lat[r] = -1;
    while (seen != 4'hf && cyc < 200) begin
      for (int r = 0; r < 4; r++)
        if (!seen[r]) chk1($sformatf("busy_in_flight[%0d]", r), bz[r], 1'b1);
      tick();
      cyc++;
      for (int r = 0; r < 4; r++)
        if (!seen[r] && ov[r]) begin
          seen[r] = 1'b1;
          lat[r] = cyc;
        end
    end
    for (int r = 0; r < 4; r++) begin
      chk($sformatf("latency[%0d]", r), 512'(lat[r]), 512'(inst_lat[r]));
      chk($sformatf("keystream[%0d]", r), ks[r], exp_ks[r]);
      chk1($sformatf("out_busy[%0d]", r), bz[r], 1'b0);
      chk1($sformatf("out_in_ready[%0d]", r), ir[r], 1'b0);
    end
  endtask

  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      for (int r = 0; r < 4; r++) begin
        chk1($sformatf("stall_valid[%0d]", r), ov[r], 1'b1);
        chk1($sformatf("stall_in_ready[%0d]", r), ir[r], 1'b0);
        chk($sformatf("stall_data[%0d]", r), ks[r], exp_ks[r]);
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk1($sformatf("release_valid[%0d]", r), ov[r], 1'b0);
      chk1($sformatf("release_in_ready[%0d]", r), ir[r], 1'b1);
    end
  endtask

  task automatic check_words(input string tag, input int word, input logic [31:0] value);
    for (int r = 0; r < 3; r++)
      chk($sformatf("%s_w%0d[%0d]", tag, word, r), 512'(ks[r][32*word +: 32]), 512'(value));
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    key = '0;
    nonce = '0;
    counter = '0;
    din = '0;
    for (int i = 0; i < 32; i++) rfc_k[8*i +: 8] = 8'(i);
    rfc_n = {32'h00000000, 32'h4a000000, 32'h09000000};

    // reset state
    repeat (3) tick();
    for (int r = 0; r < 4; r++) begin
      chk1($sformatf("rst_in_ready[%0d]", r), ir[r], 1'b1);
      chk1($sformatf("rst_out_valid[%0d]", r), ov[r], 1'b0);
      chk1($sformatf("rst_busy[%0d]", r), bz[r], 1'b0);
      chk($sformatf("rst_keystream[%0d]", r), ks[r], '0);
    end
    rst_n = 1'b1;
    tick();

    // RFC 7539 2.3.2 vector on all lane widths
    set_req(rfc_k, rfc_n, 32'd1, '0);
    accept();
    wait_out();
    check_words("rfc", 0, 32'he4e7f110);
    check_words("rfc", 1, 32'h15593bd1);
    check_words("rfc", 2, 32'h1fdd0f50);
    check_words("rfc", 3, 32'hc47120a3);
    check_words("rfc", 15, 32'h4e3c50a2);
    release_out();

`ifdef CHACHA_XOR_EN
    set_req(rfc_k, rfc_n, 32'd1, '1);
    accept();
    wait_out();
    chk("xor_ones_inverse", ks[0], ~chacha_ref(rfc_k, rfc_n, 32'd1, 20));
    check_words("rfc_inv", 0, ~32'he4e7f110);
    release_out();
`endif

    // all-zero key/nonce/counter
    set_req('0, '0, 32'd0, '0);
    accept();
    wait_out();
    check_words("zero", 0, 32'hade0b876);
    check_words("zero", 1, 32'h903df1a0);
    release_out();

    // backpressure with a second request held during the stall
    rd = rnd512();
    set_req(rd[255:0], rd[351:256], rd[383:352], rnd512());
    accept();
    wait_out();
    rd = rnd512();
    rk = rd[255:0];
    rn = rd[351:256];
    key = rk;
    nonce = rn;
    counter = rd[383:352];
    in_valid = 1'b1;
    stall(10);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      chk1($sformatf("bp_release_valid[%0d]", r), ov[r], 1'b0);
      chk1($sformatf("bp_release_in_ready[%0d]", r), ir[r], 1'b1);
    end
    set_req(rk, rn, rd[383:352], rnd512());
    accept();
    wait_out();
    release_out();

    // asynchronous reset in round cycle 5
    rd = rnd512();
    set_req(rd[255:0], rd[351:256], rd[383:352], rnd512());
    accept();
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) begin
      chk1($sformatf("midrst_valid[%0d]", r), ov[r], 1'b0);
      chk1($sformatf("midrst_in_ready[%0d]", r), ir[r], 1'b1);
      chk1($sformatf("midrst_busy[%0d]", r), bz[r], 1'b0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    set_req(rfc_k, rfc_n, 32'd1, '0);
    accept();
    wait_out();
    check_words("rfc_after_rst", 0, 32'he4e7f110);
    release_out();

    // asynchronous reset while a block is being presented
    rd = rnd512();
    set_req(rd[255:0], rd[351:256], rd[383:352], rnd512());
    accept();
    wait_out();
    rst_n = 1'b0;
    #1;
    for (int r = 0; r < 4; r++) begin
      chk1($sformatf("outrst_valid[%0d]", r), ov[r], 1'b0);
      chk($sformatf("outrst_keystream[%0d]", r), ks[r], '0);
    end
    tick();
    rst_n = 1'b1;
    tick();

    // random requests, including a wrapped counter, with random release delay
    for (int t = 0; t < 5; t++) begin
      rd = rnd512();
      set_req(rd[255:0], rd[351:256], (t == 0) ? 32'hffffffff : rd[383:352], rnd512());
      accept();
      wait_out();
      stall($urandom_range(0, 3));
      release_out();
    end

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
